// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter with transmit FIFO, optional parity and 1/2 stop bits
module uart_tx_param #(
    parameter int BAUD_DIV   = 10416,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 tx_en,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 load,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_full,
    output logic                 overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 r_state, w_state_n;
    logic [BW-1:0]          r_baud, w_baud_n;
    logic [IW-1:0]          r_idx, w_idx_n;
    logic [DATA_BITS-1:0]   r_shift, w_shift_n;
    logic                   r_par, w_par_n;
    logic                   r_tx_out, r_done, r_overflow;
    logic                   w_done_n, w_line, w_pop, w_push, w_empty, w_full, w_bit_end;
    logic [AW:0]            r_wr_ptr, r_rd_ptr;
    logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0]   w_head;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push    = load && !w_full;
    assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_bit_end = (r_baud == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_overflow <= load && w_full;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_baud_n  = w_bit_end ? '0 : r_baud + 1'b1;
        w_idx_n   = r_idx;
        w_shift_n = r_shift;
        w_par_n   = r_par;
        w_pop     = 1'b0;
        w_done_n  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_baud_n = '0;
                if (!w_empty && tx_en) begin
                    w_pop     = 1'b1;
                    w_state_n = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_n = S_DATA;
                    w_idx_n   = '0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_idx == DATA_LAST) begin
                        w_idx_n   = '0;
                        w_state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_idx_n   = r_idx + 1'b1;
                        w_shift_n = r_shift >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_n = S_STOP;
                    w_idx_n   = '0;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_idx == STOP_LAST) begin
                        w_done_n  = 1'b1;
                        w_idx_n   = '0;
                        if (!w_empty && tx_en) begin
                            w_pop     = 1'b1;
                            w_state_n = S_START;
                        end else begin
                            w_state_n = S_IDLE;
                        end
                    end else begin
                        w_idx_n = r_idx + 1'b1;
                    end
                end
            end
            default: w_state_n = S_IDLE;
        endcase
        if (w_pop) begin
            w_shift_n = w_head;
            w_par_n   = (^w_head) ^ PAR_ODD;
            w_baud_n  = '0;
        end
    end

    // The line level is derived from the next state so tx_out is registered without an extra bit of lag.
    always_comb begin
        w_line = 1'b1;
        case (w_state_n)
            S_START:  w_line = 1'b0;
            S_DATA:   w_line = w_shift_n[0];
            S_PARITY: w_line = w_par_n;
            default:  w_line = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_tx_out <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_baud   <= w_baud_n;
            r_idx    <= w_idx_n;
            r_shift  <= w_shift_n;
            r_par    <= w_par_n;
            r_tx_out <= w_line;
            r_done   <= w_done_n;
        end
    end

    assign tx_out   = r_tx_out;
    assign tx_busy  = (r_state != S_IDLE);
    assign tx_done  = r_done;
    assign tx_full  = w_full;
    assign overflow = r_overflow;

endmodule
